// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter:
// FSM states, access size codes and requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    function automatic state_e busy_state(input req_id_e id);
        return (id == REQ_D) ? ST_BUSY_D : ST_BUSY_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory handshake signals of the arbiter.
// master = arbiter view, slave = requesters plus memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, flush,
        output if_rdata, if_valid, if_stall,
        input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output if_req, if_addr, flush,
        input  if_rdata, if_valid, if_stall,
        output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_streak.sv
// Saturating count of data grants given while fetch waits.
// sat_o tells the arbiter to let fetch in next.
module arb_streak_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAXV = CW'(MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat_o = (cnt_q >= MAXV);

    // clear wins over increment; hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // streak register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one req/ack memory port.
// Data wins unless fetch has waited MAX_DATA_STREAK data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.master bus
);
    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [1:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              dm_valid_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              squash_q;

    logic idle;
    logic sat;
    logic grant_d;
    logic grant_i;
    logic strk_inc;
    logic strk_clr;

    // arbitration decision for the current IDLE cycle
    always_comb begin
        idle     = (state_q == ST_IDLE);
        grant_d  = idle & bus.dm_req & (~bus.if_req | ~sat);
        grant_i  = idle & ~grant_d & bus.if_req & ~bus.flush;
        strk_inc = grant_d & bus.if_req;
        strk_clr = grant_i | ~bus.if_req;
    end

    arb_streak_counter #(
        .MAX   (MAX_DATA_STREAK)
    ) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc_i (strk_inc),
        .clr_i (strk_clr),
        .sat_o (sat)
    );

    // FSM with registered request and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            squash_q    <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        state_q     <= busy_state(REQ_D);
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_size_q  <= bus.dm_size;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                    end else if (grant_i) begin
                        state_q     <= busy_state(REQ_I);
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_size_q  <= SZ_WORD;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                ST_BUSY_I: begin
                    if (bus.mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        squash_q  <= 1'b0;
                        if (!squash_q && !bus.flush) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else if (bus.flush) begin
                        squash_q <= 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (bus.mem_ack) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// sequences for starvation, flush, and async reset corners.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mem_lat = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic wait_valid(input bit d, input int budget,
                              output int n);
        n = 0;
        while (!(d ? bus.dm_valid : bus.if_valid) && n < budget) begin
            tick;
            n++;
        end
    endtask

    // memory model: ack mem_lat cycles after mem_req is first seen
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end else if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end else if (bus.mem_req) begin
                if (cnt >= mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd_model(bus.mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [1:0]  dsz;
        logic [31:0] da;
        logic [31:0] dwd;
        int          lat;
        logic        exp_we;
        logic [1:0]  exp_sz;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        bit          exp_d;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n;
        int dgr;
        int p;
        bit igr;
        logic prev;

        vt[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0,
                  0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 32'h5A5A_0100, 1'b0};
        vt[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,
                  1, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 32'h5A5A_1000, 1'b1};
        vt[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h0000_2002,
                  32'h0000_BEEF, 2, 1'b1, 2'b01, 32'h0000_2002,
                  32'h0000_BEEF, 32'h5A5A_1000, 1'b1};
        vt[3] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 2'b00, 32'h0000_3001,
                  32'h0, 0, 1'b0, 2'b00, 32'h0000_3001, 32'h0,
                  32'h5A5A_3001, 1'b1};
        vt[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0,
                  3, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_FFFC, 1'b0};

        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.flush    = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_size  = 2'b00;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;

        // reset state
        tick;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_dm_valid", bus.dm_valid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_size", bus.mem_size, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_stall0", bus.if_stall, 0);
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        #1;
        chk("rst_if_stall1", bus.if_stall, 1);
        chk("rst_dm_stall1", bus.dm_stall, 1);
        tick;
        chk("rst_no_grant", bus.mem_req, 0);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        reset = 1'b1;
        tick;
        tick;

        // table-driven single transactions
        for (int k = 0; k < 5; k++) begin
            mem_lat      = vt[k].lat;
            bus.if_req   = vt[k].ifr;
            bus.if_addr  = vt[k].ia;
            bus.dm_req   = vt[k].dr;
            bus.dm_we    = vt[k].dwe;
            bus.dm_size  = vt[k].dsz;
            bus.dm_addr  = vt[k].da;
            bus.dm_wdata = vt[k].dwd;
            tick;
            chk($sformatf("v%0d_mem_req", k), bus.mem_req, 1);
            chk($sformatf("v%0d_mem_addr", k), bus.mem_addr, vt[k].exp_addr);
            chk($sformatf("v%0d_mem_we", k), bus.mem_we, vt[k].exp_we);
            chk($sformatf("v%0d_mem_size", k), bus.mem_size, vt[k].exp_sz);
            chk($sformatf("v%0d_mem_wdata", k), bus.mem_wdata, vt[k].exp_wd);
            chk($sformatf("v%0d_stall_busy", k),
                vt[k].exp_d ? bus.dm_stall : bus.if_stall, 1);
            wait_valid(vt[k].exp_d, 12, n);
            chk($sformatf("v%0d_latency", k), n + 1, vt[k].lat + 2);
            chk($sformatf("v%0d_rdata", k),
                vt[k].exp_d ? bus.dm_rdata : bus.if_rdata, vt[k].exp_rd);
            chk($sformatf("v%0d_stall_done", k),
                vt[k].exp_d ? bus.dm_stall : bus.if_stall, 0);
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
            tick;
            tick;
        end

        // both at once, 3-cycle ack: D first, I right after
        mem_lat      = 2;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0400;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_size  = SZ_WORD;
        bus.dm_addr  = 32'h0000_4004;
        tick;
        chk("t2_d_first", bus.mem_addr, 32'h0000_4004);
        wait_valid(1'b1, 10, n);
        chk("t2_d_latency", n + 1, 4);
        bus.dm_req = 1'b0;
        tick;
        chk("t2_i_next_req", bus.mem_req, 1);
        chk("t2_i_next_addr", bus.mem_addr, 32'h0000_0400);
        wait_valid(1'b0, 10, n);
        chk("t2_i_wait", n, 3);
        chk("t2_i_rdata", bus.if_rdata, 32'h5A5A_0400);
        bus.if_req = 1'b0;
        tick;
        tick;

        // starvation bound: four D grants then fetch
        mem_lat      = 0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_size  = SZ_WORD;
        bus.dm_addr  = 32'h0000_0800;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0900;
        dgr  = 0;
        igr  = 1'b0;
        prev = 1'b0;
        n    = 0;
        while (!igr && n < 40) begin
            tick;
            n++;
            if (bus.mem_req && !prev) begin
                if (bus.mem_addr == 32'h0000_0900) igr = 1'b1;
                else dgr++;
            end
            prev = bus.mem_req;
        end
        chk("t3_d_grants", dgr, 4);
        chk("t3_i_granted", {31'b0, igr}, 1);
        chk("t3_streak_clr", 32'(dut.u_streak.cnt_q), 0);
        wait_valid(1'b0, 10, n);
        chk("t3_i_rdata", bus.if_rdata, 32'h5A5A_0900);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick;
        tick;

        // flush one cycle after I grant squashes the fetch
        mem_lat     = 2;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0180;
        tick;
        chk("t4_grant", bus.mem_req, 1);
        bus.flush = 1'b1;
        tick;
        bus.flush   = 1'b0;
        bus.if_addr = 32'h0000_0200;
        chk("t4_no_valid_c2", bus.if_valid, 0);
        tick;
        chk("t4_no_valid_c3", bus.if_valid, 0);
        tick;
        chk("t4_no_valid_c4", bus.if_valid, 0);
        tick;
        chk("t4_new_req", bus.mem_req, 1);
        chk("t4_new_addr", bus.mem_addr, 32'h0000_0200);
        wait_valid(1'b0, 10, n);
        chk("t4_new_wait", n, 3);
        chk("t4_new_rdata", bus.if_rdata, 32'h5A5A_0200);
        bus.if_req = 1'b0;
        tick;
        tick;

        // flush in IDLE blocks the grant; flush with ack kills valid
        mem_lat     = 1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0240;
        bus.flush   = 1'b1;
        tick;
        chk("t5_idle_flush_block", bus.mem_req, 0);
        bus.flush = 1'b0;
        tick;
        chk("t5_grant_after", bus.mem_req, 1);
        tick;
        bus.flush = 1'b1;
        tick;
        chk("t5_ack_flush_valid", bus.if_valid, 0);
        chk("t5_back_idle", bus.mem_req, 0);
        bus.flush  = 1'b0;
        bus.if_req = 1'b0;
        tick;
        chk("t5_still_no_valid", bus.if_valid, 0);
        chk("t5_rdata_kept", bus.if_rdata, 32'h5A5A_0200);
        mem_lat     = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_02C0;
        tick;
        wait_valid(1'b0, 8, n);
        chk("t5_after_wait", n + 1, 2);
        chk("t5_after_rdata", bus.if_rdata, 32'h5A5A_02C0);
        bus.if_req = 1'b0;
        tick;

        // flush has no effect on a data access
        mem_lat     = 1;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_size = SZ_WORD;
        bus.dm_addr = 32'h0000_5000;
        tick;
        bus.flush = 1'b1;
        tick;
        tick;
        chk("t5_d_valid", bus.dm_valid, 1);
        chk("t5_d_rdata", bus.dm_rdata, 32'h5A5A_5000);
        bus.flush  = 1'b0;
        bus.dm_req = 1'b0;
        tick;

        // async reset mid BUSY_D, then a byte store
        mem_lat     = 5;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h0000_6000;
        tick;
        chk("t6_busy", bus.mem_req, 1);
        tick;
        reset = 1'b0;
        #1;
        chk("t6_async_mem_req", bus.mem_req, 0);
        chk("t6_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        bus.dm_req = 1'b0;
        tick;
        chk("t6_rst_dm_rdata", bus.dm_rdata, 0);
        tick;
        reset = 1'b1;
        tick;
        mem_lat      = 0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_size  = SZ_BYTE;
        bus.dm_addr  = 32'h0000_6003;
        bus.dm_wdata = 32'hDEAD_BEEF;
        tick;
        chk("t6_mem_we", bus.mem_we, 1);
        chk("t6_mem_size", bus.mem_size, 0);
        chk("t6_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        p = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.dm_valid) begin
                p++;
                bus.dm_req = 1'b0;
            end
            tick;
        end
        chk("t6_one_pulse", p, 1);
        chk("t6_store_rdata", bus.dm_rdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
